// File: rtl/ln_seq_ctrl_pkg.sv
// Shared types and constants for the ln-stage sequencer: state encoding,
// fixed-point reference constants and small helper functions.
package ln_seq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    localparam logic [31:0] Q4_28_ONE = 32'h1000_0000;
    localparam logic [31:0] LN2_Q2_30 = 32'h2C5C_85FD;

    function automatic int timer_width(input int arm_cycles, input int timeout_cycles);
        int max_v;
        max_v = (arm_cycles > timeout_cycles) ? arm_cycles : timeout_cycles;
        return (max_v > 2) ? $clog2(max_v) : 1;
    endfunction

    // Integer part of a 4.28 value is zero when the sum is below 1.0.
    function automatic logic range_err(input logic [3:0] int_bits);
        return (int_bits == 4'd0);
    endfunction

endpackage

// File: rtl/ln_seq_ctrl_if.sv
// Handshake bundle between the adder tree, the ln datapath and the subtractor,
// as seen by the sequencer (slave) and its environment (master).
interface ln_seq_ctrl_if #(parameter int DATA_SIZE = 32);

    logic [DATA_SIZE-1:0] sum_data_i;
    logic                 sum_valid_i;
    logic                 sum_ready_o;
    logic                 flush_i;
    logic                 ln_reset_n_o;
    logic [DATA_SIZE-1:0] ln_data_o;
    logic                 ln_data_valid_o;
    logic [DATA_SIZE-1:0] ln_result_i;
    logic                 ln_result_valid_i;
    logic [DATA_SIZE-1:0] result_o;
    logic                 result_valid_o;
    logic                 result_ready_i;
    logic                 err_o;
    logic                 busy_o;

    modport slave (
        input  sum_data_i, sum_valid_i, flush_i, ln_result_i, ln_result_valid_i, result_ready_i,
        output sum_ready_o, ln_reset_n_o, ln_data_o, ln_data_valid_o, result_o, result_valid_o,
               err_o, busy_o
    );

    modport master (
        output sum_data_i, sum_valid_i, flush_i, ln_result_i, ln_result_valid_i, result_ready_i,
        input  sum_ready_o, ln_reset_n_o, ln_data_o, ln_data_valid_o, result_o, result_valid_o,
               err_o, busy_o
    );

endinterface

// File: rtl/ln_seq_ctrl_timer.sv
// Loadable down-counter shared by the arm delay and the run watchdog;
// saturates at zero and reports when it gets there.
module ln_seq_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: load has priority over decrement.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/ln_seq_ctrl.sv
// Sequencer around the one-shot ln datapath: range-check, re-arm, run, hand off.
// Optional run watchdog enabled by defining LN_TIMEOUT_EN.
module ln_seq_ctrl
    import ln_seq_ctrl_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int ARM_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    ln_seq_ctrl_if.slave  bus
);

    localparam int TW = timer_width(ARM_CYCLES, TIMEOUT_CYCLES);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_sum_ready;
    logic                 r_ln_reset_n;
    logic                 r_ln_dv;
    logic                 r_result_valid;
    logic                 r_err;
    logic                 r_busy;
    logic [DATA_SIZE-1:0] r_sum;
    logic [DATA_SIZE-1:0] r_result;

    logic                 w_tmr_load;
    logic [TW-1:0]        w_tmr_val;
    logic                 w_tmr_dec;
    logic                 w_tmr_zero;
    logic                 w_sum_latch;
    logic                 w_res_cap;
    logic [DATA_SIZE-1:0] w_res_val;
    logic                 w_err_val;

    ln_seq_timer #(.WIDTH(TW)) u_timer (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Next-state logic plus timer, sum-latch and result-capture controls.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        w_tmr_dec   = 1'b0;
        w_sum_latch = 1'b0;
        w_res_cap   = 1'b0;
        w_res_val   = '0;
        w_err_val   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.sum_valid_i && r_sum_ready) begin
                    w_sum_latch = 1'b1;
                    if (range_err(bus.sum_data_i[DATA_SIZE-1 -: 4])) begin
                        w_state_nxt = DONE;
                        w_res_cap   = 1'b1;
                        w_err_val   = 1'b1;
                    end else begin
                        w_state_nxt = ARM;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = TW'(ARM_CYCLES - 1);
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ARM: begin
                if (w_tmr_zero) begin
                    w_state_nxt = RUN;
`ifdef LN_TIMEOUT_EN
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TW'(TIMEOUT_CYCLES - 1);
`endif
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            RUN: begin
                if (bus.ln_result_valid_i) begin
                    w_state_nxt = DONE;
                    w_res_cap   = 1'b1;
                    w_res_val   = bus.ln_result_i;
`ifdef LN_TIMEOUT_EN
                end else if (w_tmr_zero) begin
                    // ln never normalised its input: report a timeout error.
                    w_state_nxt = DONE;
                    w_res_cap   = 1'b1;
                    w_err_val   = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                end
`else
                end else begin
                    w_state_nxt = RUN;
                end
`endif
            end
            DONE: begin
                if (r_result_valid && bus.result_ready_i) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; flush overrides every transition.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            r_state        <= IDLE;
            r_sum_ready    <= 1'b0;
            r_ln_reset_n   <= 1'b0;
            r_ln_dv        <= 1'b0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_sum          <= '0;
            r_result       <= '0;
        end else if (bus.flush_i) begin
            r_state        <= IDLE;
            r_sum_ready    <= 1'b1;
            r_ln_reset_n   <= 1'b0;
            r_ln_dv        <= 1'b0;
            r_result_valid <= 1'b0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_sum          <= r_sum;
            r_result       <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_sum_ready    <= (w_state_nxt == IDLE);
            r_ln_reset_n   <= (w_state_nxt == RUN);
            r_ln_dv        <= (w_state_nxt == RUN);
            r_result_valid <= (w_state_nxt == DONE);
            r_busy         <= (w_state_nxt != IDLE);
            if (w_sum_latch) begin
                r_sum <= bus.sum_data_i;
            end else begin
                r_sum <= r_sum;
            end
            if (w_res_cap) begin
                r_result <= w_res_val;
                r_err    <= w_err_val;
            end else if (w_state_nxt == IDLE) begin
                r_result <= '0;
                r_err    <= 1'b0;
            end else begin
                r_result <= r_result;
                r_err    <= r_err;
            end
        end
    end

    assign bus.sum_ready_o     = r_sum_ready;
    assign bus.ln_reset_n_o    = r_ln_reset_n;
    assign bus.ln_data_o       = r_sum;
    assign bus.ln_data_valid_o = r_ln_dv;
    assign bus.result_o        = r_result;
    assign bus.result_valid_o  = r_result_valid;
    assign bus.err_o           = r_err;
    assign bus.busy_o          = r_busy;

endmodule

// File: tb/tb_ln_seq_ctrl.sv
// Directed bench for ln_seq_ctrl with a behavioural ln datapath model.
// Define LN_TIMEOUT_EN to exercise the watchdog path.
module tb_ln_seq_ctrl;

    localparam int          LAT  = 5;
    localparam logic [31:0] ONE  = 32'h1000_0000;
    localparam logic [31:0] TWO  = 32'h2000_0000;
    localparam logic [31:0] HALF = 32'h0800_0000;
    localparam logic [31:0] LN2  = 32'h2C5C_85FD;

    logic clk;
    logic rst_n;
    logic m_stall;
    int   n_checks;
    int   n_fail;

    ln_seq_ctrl_if #(.DATA_SIZE(32)) bus ();

    ln_seq_ctrl #(.DATA_SIZE(32), .ARM_CYCLES(2), .TIMEOUT_CYCLES(64)) u_dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ln_model(input logic [31:0] x);
        if (x == ONE)      return 32'h0000_0000;
        else if (x == TWO) return LN2;
        else               return 32'h1234_5678;
    endfunction

    // ln datapath model: one-shot, result pulse LAT cycles into a held valid.
    initial begin
        int m_cnt;
        m_cnt = 0;
        bus.ln_result_valid_i = 1'b0;
        bus.ln_result_i       = 32'h0;
        forever begin
            @(negedge clk);
            if (!bus.ln_reset_n_o) begin
                m_cnt = 0;
                bus.ln_result_valid_i = 1'b0;
                bus.ln_result_i       = 32'h0;
            end else if (bus.ln_data_valid_o) begin
                bus.ln_result_valid_i = 1'b0;
                m_cnt++;
                if (m_cnt == LAT && !m_stall) begin
                    bus.ln_result_valid_i = 1'b1;
                    bus.ln_result_i       = ln_model(bus.ln_data_o);
                end
            end else begin
                bus.ln_result_valid_i = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sum; returns sampled in the cycle after acceptance (T+1).
    task automatic send_sum(input logic [31:0] d);
        for (int i = 0; i < 50 && !bus.sum_ready_o; i++) tick();
        check_eq("sum_ready_before_send", 32'(bus.sum_ready_o), 32'd1);
        bus.sum_data_i  = d;
        bus.sum_valid_i = 1'b1;
        tick();
        bus.sum_valid_i = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        for (int i = 0; i < 200 && !bus.result_valid_o; i++) tick();
        check_eq(tag, 32'(bus.result_valid_o), 32'd1);
    endtask

    initial begin
        int run_cycles;
        logic seen;
        n_checks = 0;
        n_fail   = 0;
        m_stall  = 1'b0;
        rst_n    = 1'b0;
        bus.sum_data_i     = 32'h0;
        bus.sum_valid_i    = 1'b0;
        bus.flush_i        = 1'b0;
        bus.result_ready_i = 1'b0;
        repeat (3) tick();

        // Reset values
        check_eq("rst_sum_ready",  32'(bus.sum_ready_o),     32'd0);
        check_eq("rst_ln_reset_n", 32'(bus.ln_reset_n_o),    32'd0);
        check_eq("rst_ln_dv",      32'(bus.ln_data_valid_o), 32'd0);
        check_eq("rst_ln_data",    bus.ln_data_o,            32'h0);
        check_eq("rst_res_valid",  32'(bus.result_valid_o),  32'd0);
        check_eq("rst_result",     bus.result_o,             32'h0);
        check_eq("rst_err",        32'(bus.err_o),           32'd0);
        check_eq("rst_busy",       32'(bus.busy_o),          32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_sum_ready", 32'(bus.sum_ready_o), 32'd1);

        // T1: 1.0 -> 0, RUN begins at T+3
        send_sum(ONE);
        check_eq("t1_busy",      32'(bus.busy_o),          32'd1);
        check_eq("t1_sum_ready", 32'(bus.sum_ready_o),     32'd0);
        check_eq("t1_dv_t1",     32'(bus.ln_data_valid_o), 32'd0);
        tick();
        check_eq("t1_dv_t2",     32'(bus.ln_data_valid_o), 32'd0);
        tick();
        check_eq("t1_dv_t3",     32'(bus.ln_data_valid_o), 32'd1);
        check_eq("t1_lnrst_t3",  32'(bus.ln_reset_n_o),    32'd1);
        check_eq("t1_ln_data",   bus.ln_data_o,            ONE);
        wait_result("t1_res_valid");
        check_eq("t1_result",    bus.result_o,             32'h0);
        check_eq("t1_err",       32'(bus.err_o),           32'd0);
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        check_eq("t1_valid_drop", 32'(bus.result_valid_o), 32'd0);
        check_eq("t1_idle_ready", 32'(bus.sum_ready_o),    32'd1);

        // T2: 2.0 -> ln2, ln reset low two cycles before RUN, ready already high
        bus.result_ready_i = 1'b1;
        send_sum(TWO);
        check_eq("t2_lnrst_t1", 32'(bus.ln_reset_n_o), 32'd0);
        tick();
        check_eq("t2_lnrst_t2", 32'(bus.ln_reset_n_o), 32'd0);
        tick();
        check_eq("t2_lnrst_t3", 32'(bus.ln_reset_n_o), 32'd1);
        wait_result("t2_res_valid");
        check_eq("t2_result",   bus.result_o,          LN2);
        check_eq("t2_err",      32'(bus.err_o),        32'd0);
        check_eq("t2_lnrst_done", 32'(bus.ln_reset_n_o), 32'd0);
        tick();
        bus.result_ready_i = 1'b0;
        check_eq("t2_valid_drop", 32'(bus.result_valid_o), 32'd0);

        // T3: 0.5 -> range error at T+1, ln never driven
        send_sum(HALF);
        check_eq("t3_res_valid", 32'(bus.result_valid_o),  32'd1);
        check_eq("t3_err",       32'(bus.err_o),           32'd1);
        check_eq("t3_result",    bus.result_o,             32'h0);
        check_eq("t3_dv",        32'(bus.ln_data_valid_o), 32'd0);
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        check_eq("t3_dv_after",  32'(bus.ln_data_valid_o), 32'd0);
        check_eq("t3_idle",      32'(bus.busy_o),          32'd0);

        // T4: back-pressure in DONE for 5 cycles
        send_sum(TWO);
        wait_result("t4_res_valid");
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_hold_result", bus.result_o,            LN2);
            check_eq("t4_hold_valid",  32'(bus.result_valid_o), 32'd1);
            check_eq("t4_sum_ready",   32'(bus.sum_ready_o),    32'd0);
            tick();
        end
        bus.result_ready_i = 1'b1;
        check_eq("t4_still_valid", 32'(bus.result_valid_o), 32'd1);
        tick();
        bus.result_ready_i = 1'b0;
        check_eq("t4_valid_drop", 32'(bus.result_valid_o), 32'd0);
        check_eq("t4_idle_ready", 32'(bus.sum_ready_o),    32'd1);
        check_eq("t4_idle_busy",  32'(bus.busy_o),         32'd0);

        // T5: flush three cycles into RUN, then a normal vector
        send_sum(TWO);
        tick();
        tick();
        check_eq("t5_in_run", 32'(bus.ln_data_valid_o), 32'd1);
        repeat (3) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check_eq("t5_busy",   32'(bus.busy_o),         32'd0);
        check_eq("t5_lnrst",  32'(bus.ln_reset_n_o),   32'd0);
        check_eq("t5_ready",  32'(bus.sum_ready_o),    32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen = seen | bus.result_valid_o;
            tick();
        end
        check_eq("t5_no_result", 32'(seen), 32'd0);
        bus.result_ready_i = 1'b1;
        send_sum(ONE);
        wait_result("t5_next_valid");
        check_eq("t5_next_result", bus.result_o,   32'h0);
        check_eq("t5_next_err",    32'(bus.err_o), 32'd0);
        tick();
        bus.result_ready_i = 1'b0;

        // T6: ln never answers
        m_stall = 1'b1;
        send_sum(TWO);
`ifdef LN_TIMEOUT_EN
        run_cycles = 0;
        for (int i = 0; i < 200 && !bus.result_valid_o; i++) begin
            if (bus.ln_data_valid_o) run_cycles++;
            tick();
        end
        check_eq("t6_res_valid",  32'(bus.result_valid_o), 32'd1);
        check_eq("t6_run_cycles", 32'(run_cycles),         32'd64);
        check_eq("t6_err",        32'(bus.err_o),          32'd1);
        check_eq("t6_result",     bus.result_o,            32'h0);
        bus.result_ready_i = 1'b1;
        tick();
        bus.result_ready_i = 1'b0;
        check_eq("t6_idle", 32'(bus.busy_o), 32'd0);
`else
        run_cycles = 0;
        repeat (100) tick();
        check_eq("t6_busy",      32'(bus.busy_o),         32'd1);
        check_eq("t6_no_result", 32'(bus.result_valid_o), 32'd0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check_eq("t6_flushed", 32'(bus.busy_o), 32'd0);
`endif
        m_stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
